// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin scheduler that shares one APB bridge among
// NREQ local requesters. Only one transfer is in flight at any time.
//
// Ports
//   pclk, presetn            clock (rising edge), async active-low reset
//   req_valid/write/addr/wdata   per-requester request; slice i = [i*W +: W]
//   req_ready                one-hot combinational accept (IDLE only)
//   rsp_valid                one-hot, 1-cycle response pulse to the owner
//   rsp_rdata, rsp_err       response payload; held until the next response
//   grant_id                 index of the current/last owner
//   timeout_flag             sticky; set when a transfer times out
//   ptransfer/pwrite/paddr/pwdata   request side of the bridge
//   pready/pslverr/prdata           completion side of the bridge

// Per-requester slice: works out whether this lane wins arbitration, and
// contributes its payload to the one-hot OR-mux in the top level.
module apb_rr_lane #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] above,      // lanes with index strictly above ptr
  input  logic            wrap,       // no request above ptr: scan from lane 0
  input  logic [IW-1:0]   ptr,
  input  logic [IW-1:0]   grant_id,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            is_above,
  output logic            gnt,
  output logic            owner,
  output logic            write_term,
  output logic [IW-1:0]   id_term,
  output logic [AW-1:0]   addr_term,
  output logic [DW-1:0]   wdata_term
);
  localparam logic [IW-1:0]   ID  = IW'(LANE);
  localparam logic [NREQ-1:0] LOW = NREQ'((1 << LANE) - 1);

  logic [NREQ-1:0] cand;

  assign is_above = (ID > ptr);
  // Rotating priority = lowest-index request above ptr, else lowest overall.
  assign cand       = wrap ? req_valid : (req_valid & above);
  assign gnt        = cand[LANE] && !(|(cand & LOW));
  assign owner      = (grant_id == ID);
  assign write_term = gnt & req_write;
  assign id_term    = gnt ? ID : '0;
  assign addr_term  = gnt ? req_addr : '0;
  assign wdata_term = gnt ? req_wdata : '0;
endmodule

module apb_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [IW-1:0]      grant_id,
  output logic               timeout_flag,
  output logic               ptransfer,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic               pready,
  input  logic               pslverr,
  input  logic [DW-1:0]      prdata
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] ptr;
  logic [TW-1:0] timer;

  logic [NREQ-1:0] above, gnt_vec, owner_vec, wr_terms;
  logic [NREQ-1:0][IW-1:0] id_terms;
  logic [NREQ-1:0][AW-1:0] addr_terms;
  logic [NREQ-1:0][DW-1:0] wdata_terms;
  logic [NREQ:0][IW-1:0]   id_acc;
  logic [NREQ:0][AW-1:0]   addr_acc;
  logic [NREQ:0][DW-1:0]   wdata_acc;
  logic wrap, any_req, time_up;

  assign wrap    = ~|(req_valid & above);
  assign any_req = |req_valid;
  assign time_up = (timer == TMAX);

  assign id_acc[0]    = '0;
  assign addr_acc[0]  = '0;
  assign wdata_acc[0] = '0;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    apb_rr_lane #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW), .LANE(i)) u_lane (
      .req_valid (req_valid),
      .above     (above),
      .wrap      (wrap),
      .ptr       (ptr),
      .grant_id  (grant_id),
      .req_write (req_write[i]),
      .req_addr  (req_addr[i*AW +: AW]),
      .req_wdata (req_wdata[i*DW +: DW]),
      .is_above  (above[i]),
      .gnt       (gnt_vec[i]),
      .owner     (owner_vec[i]),
      .write_term(wr_terms[i]),
      .id_term   (id_terms[i]),
      .addr_term (addr_terms[i]),
      .wdata_term(wdata_terms[i])
    );
    assign id_acc[i+1]    = id_acc[i]    | id_terms[i];
    assign addr_acc[i+1]  = addr_acc[i]  | addr_terms[i];
    assign wdata_acc[i+1] = wdata_acc[i] | wdata_terms[i];
  end

  assign req_ready = (state == S_IDLE) ? gnt_vec : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_BUSY;
      S_BUSY:  if (pready || time_up) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ptr          <= IW'(NREQ - 1);
      timer        <= '0;
      grant_id     <= '0;
      ptransfer    <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          pwrite    <= |wr_terms;
          paddr     <= addr_acc[NREQ];
          pwdata    <= wdata_acc[NREQ];
          ptransfer <= 1'b1;
          grant_id  <= id_acc[NREQ];
          ptr       <= id_acc[NREQ];
          timer     <= '0;
        end
        S_BUSY: begin
          // pready takes precedence over an expiry on the same cycle
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            rsp_valid <= owner_vec;
            ptransfer <= 1'b0;
          end else if (time_up) begin
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            timeout_flag <= 1'b1;
            rsp_valid    <= owner_vec;
            ptransfer    <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: rsp_valid <= '0;
        default: ;
      endcase
    end
  end
endmodule
